openofdm_rx_pkt_ctrl: RTL and testbench
=======================================

// Module: openofdm_rx_pkt_ctrl
// PURPOSE
//  Per-packet sequencer/watchdog for the dot11 receive core inside openofdm_rx.
//  - Tracks each packet: preamble -> SIG -> payload -> FCS, from dot11 status strobes.
//  - On a stall, unsupported header or disable, pulses a core reset to return dot11 to search.
//  - Reports one result code per packet to rx_intf and the status registers.
// PARAMETERS
//  RST_CYCLES  4   cycles core_rst is held high per abort (>=1)
//  TMR_WIDTH   16  width of the stage timer and timeout config fields
// PORTS
//  s00_axi_aclk             in   1   clock
//  s00_axi_aresetn          in   1   async active-low reset
//  enable                   in   1   1 = sequencing active; 0 = abort current packet, stay IDLE
//  short_preamble_detected  in   1   dot11 short-preamble flag
//  long_preamble_detected   in   1   dot11 long-preamble flag
//  pkt_header_valid_strobe  in   1   SIG decode done
//  pkt_header_valid         in   1   SIG parity/rate ok (sampled with strobe)
//  ht_unsupport             in   1   HT mode unsupported (sampled with strobe)
//  byte_out_strobe          in   1   payload byte produced
//  fcs_out_strobe           in   1   FCS check done
//  fcs_ok                   in   1   FCS result (sampled with strobe)
//  cfg_long_tmo             in   TMR_WIDTH  max cycles WAIT_LONG; 0 = disabled
//  cfg_sig_tmo              in   TMR_WIDTH  max cycles WAIT_SIG; 0 = disabled
//  cfg_byte_tmo             in   TMR_WIDTH  max cycles between payload bytes; 0 = disabled
//  core_rst                 out  1   OR-ed into dot11 reset
//  rx_busy                  out  1   state != IDLE
//  ctrl_state               out  3   current state encoding
//  pkt_done_stb             out  1   one-cycle pulse per terminated packet
//  result_code              out  3   result of last packet, held until next pkt_done_stb
// BEHAVIOUR
//  Reset: state=IDLE, core_rst=0, pkt_done_stb=0, result_code=0, timer=0; all outputs registered.
//  States: IDLE=0, WAIT_LONG=1, WAIT_SIG=2, PAYLOAD=3, FLUSH=4.
//  - IDLE -> WAIT_LONG when enable & short_preamble_detected.
//  - WAIT_LONG -> WAIT_SIG on long_preamble_detected.
//  - WAIT_SIG on header strobe: ht_unsupport -> FLUSH code 5; !valid -> FLUSH code 4; else PAYLOAD.
//  - PAYLOAD on fcs_out_strobe -> IDLE, code 0 (fcs_ok) or 1 (bad); no core reset.
//  - FLUSH: core_rst=1 for exactly RST_CYCLES cycles, then IDLE with core_rst=0.
//  Timer: zeroed on every state entry, and in PAYLOAD on each byte_out_strobe; else +1, saturating.
//  Timeout when cfg!=0 & timer==cfg-1 -> FLUSH; codes: 2 long, 3 sig, 6 byte.
//  enable=0 in WAIT_LONG/WAIT_SIG/PAYLOAD -> FLUSH code 7; enable=0 during FLUSH completes it.
//  Result codes: 0 ok, 1 fcs bad, 2 long tmo, 3 sig tmo, 4 hdr invalid, 5 ht unsup, 6 byte tmo, 7 disabled.
//  Latency: pkt_done_stb and new result_code appear 1 cycle after the terminating event.
//  FLUSH entry: pkt_done_stb asserts in the same cycle core_rst first goes high.
//  Priority in one cycle: enable=0 > event strobe > timeout.
//    e.g. fcs_out_strobe at timeout cycle -> code 0/1, not 6.
//  short_preamble_detected outside IDLE is ignored; inputs ignored during FLUSH.
//  Async reset mid-packet: immediate return to reset values; no pkt_done_stb issued.
// CONFIGURATION
//  OPENOFDM_RX_PKT_STATS_EN defined:
//    adds outputs pkt_ok_cnt[15:0] (code 0) and pkt_err_cnt[15:0] (codes 1-7).
//    Counters increment on pkt_done_stb, saturate at 16'hFFFF, clear on reset only.
//  Undefined: these ports and counters do not exist; all other behaviour identical.
// TESTING
//  1. Clean pkt: short, long@+10, hdr valid@+200, 5 bytes, fcs_ok=1
//     -> pkt_done_stb once, code 0, core_rst never high.
//  2. cfg_long_tmo=100, short only -> after 100 cycles in WAIT_LONG: code 2, core_rst high 4 cycles, IDLE.
//  3. Hdr strobe with valid=1, ht_unsupport=1 -> code 5, FLUSH; valid=0 alone -> code 4.
//  4. cfg_byte_tmo=50, bytes every 40 cycles then stop -> no abort while bytes flow, code 6 after 50 idle cycles.
//  5. fcs_out_strobe on timeout cycle -> code from fcs_ok;
//     enable=0 in PAYLOAD -> code 7; cfg=0 -> never times out (10k cycles).
//  6. STATS_EN: 3 ok + 2 aborts -> ok_cnt=3, err_cnt=2; forced to 16'hFFFF stays 16'hFFFF; aresetn low mid-PAYLOAD -> IDLE, no strobe.

Source files
------------

// File: rtl/openofdm_rx_pkt_ctrl.sv
// Per-packet sequencer/watchdog for the dot11 receive core: tracks preamble/SIG/payload/FCS,
// aborts via core_rst on stall, bad header or disable. Optional counters: OPENOFDM_RX_PKT_STATS_EN.
module openofdm_rx_pkt_ctrl #(
  parameter int RST_CYCLES = 4,
  parameter int TMR_WIDTH  = 16
) (
  input  logic                 s00_axi_aclk,
  input  logic                 s00_axi_aresetn,
  input  logic                 enable,
  input  logic                 short_preamble_detected,
  input  logic                 long_preamble_detected,
  input  logic                 pkt_header_valid_strobe,
  input  logic                 pkt_header_valid,
  input  logic                 ht_unsupport,
  input  logic                 byte_out_strobe,
  input  logic                 fcs_out_strobe,
  input  logic                 fcs_ok,
  input  logic [TMR_WIDTH-1:0] cfg_long_tmo,
  input  logic [TMR_WIDTH-1:0] cfg_sig_tmo,
  input  logic [TMR_WIDTH-1:0] cfg_byte_tmo,
  output logic                 core_rst,
  output logic                 rx_busy,
  output logic [2:0]           ctrl_state,
  output logic                 pkt_done_stb,
  output logic [2:0]           result_code
`ifdef OPENOFDM_RX_PKT_STATS_EN
  ,
  output logic [15:0]          pkt_ok_cnt,
  output logic [15:0]          pkt_err_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LONG = 3'd1,
    WAIT_SIG  = 3'd2,
    PAYLOAD   = 3'd3,
    FLUSH     = 3'd4
  } state_t;

  localparam logic [2:0] CODE_OK       = 3'd0;
  localparam logic [2:0] CODE_FCS_BAD  = 3'd1;
  localparam logic [2:0] CODE_LONG_TMO = 3'd2;
  localparam logic [2:0] CODE_SIG_TMO  = 3'd3;
  localparam logic [2:0] CODE_HDR_BAD  = 3'd4;
  localparam logic [2:0] CODE_HT_UNSUP = 3'd5;
  localparam logic [2:0] CODE_BYTE_TMO = 3'd6;
  localparam logic [2:0] CODE_DISABLED = 3'd7;

  localparam logic [TMR_WIDTH-1:0] TMR_ONE  = TMR_WIDTH'(1);
  localparam logic [TMR_WIDTH-1:0] TMR_MAX  = '1;
  localparam logic [TMR_WIDTH-1:0] RST_LAST = TMR_WIDTH'(RST_CYCLES - 1);

  state_t               state;
  state_t               state_nxt;
  logic [TMR_WIDTH-1:0] timer;
  logic [TMR_WIDTH-1:0] timer_nxt;
  logic                 timer_clr;
  logic                 done_nxt;
  logic [2:0]           code_nxt;

  // A zero limit disables the watchdog; otherwise the stage may last exactly cfg cycles.
  function automatic logic tmo_hit(input logic [TMR_WIDTH-1:0] tmr,
                                   input logic [TMR_WIDTH-1:0] cfg);
    return (cfg != '0) && (tmr == (cfg - TMR_ONE));
  endfunction

  function automatic logic [TMR_WIDTH-1:0] tmr_inc(input logic [TMR_WIDTH-1:0] tmr);
    return (tmr == TMR_MAX) ? tmr : (tmr + TMR_ONE);
  endfunction

  always_comb begin
    state_nxt = state;
    timer_clr = 1'b0;
    done_nxt  = 1'b0;
    code_nxt  = result_code;
    case (state)
      IDLE: begin
        if (enable && short_preamble_detected) state_nxt = WAIT_LONG;
      end
      WAIT_LONG: begin
        if (!enable) begin
          state_nxt = FLUSH;
          done_nxt  = 1'b1;
          code_nxt  = CODE_DISABLED;
        end else if (long_preamble_detected) begin
          state_nxt = WAIT_SIG;
        end else if (tmo_hit(timer, cfg_long_tmo)) begin
          state_nxt = FLUSH;
          done_nxt  = 1'b1;
          code_nxt  = CODE_LONG_TMO;
        end
      end
      WAIT_SIG: begin
        if (!enable) begin
          state_nxt = FLUSH;
          done_nxt  = 1'b1;
          code_nxt  = CODE_DISABLED;
        end else if (pkt_header_valid_strobe) begin
          // HT-unsupported outranks a parity/rate failure reported in the same strobe.
          if (ht_unsupport) begin
            state_nxt = FLUSH;
            done_nxt  = 1'b1;
            code_nxt  = CODE_HT_UNSUP;
          end else if (!pkt_header_valid) begin
            state_nxt = FLUSH;
            done_nxt  = 1'b1;
            code_nxt  = CODE_HDR_BAD;
          end else begin
            state_nxt = PAYLOAD;
          end
        end else if (tmo_hit(timer, cfg_sig_tmo)) begin
          state_nxt = FLUSH;
          done_nxt  = 1'b1;
          code_nxt  = CODE_SIG_TMO;
        end
      end
      PAYLOAD: begin
        if (!enable) begin
          state_nxt = FLUSH;
          done_nxt  = 1'b1;
          code_nxt  = CODE_DISABLED;
        end else if (fcs_out_strobe) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          code_nxt  = fcs_ok ? CODE_OK : CODE_FCS_BAD;
        end else if (byte_out_strobe) begin
          timer_clr = 1'b1;
        end else if (tmo_hit(timer, cfg_byte_tmo)) begin
          state_nxt = FLUSH;
          done_nxt  = 1'b1;
          code_nxt  = CODE_BYTE_TMO;
        end
      end
      FLUSH: begin
        // The timer counts the core-reset cycles; all inputs are ignored here.
        if (timer == RST_LAST) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    timer_nxt = ((state_nxt != state) || timer_clr) ? '0 : tmr_inc(timer);
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state        <= IDLE;
      timer        <= '0;
      core_rst     <= 1'b0;
      rx_busy      <= 1'b0;
      pkt_done_stb <= 1'b0;
      result_code  <= CODE_OK;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      core_rst     <= (state_nxt == FLUSH);
      rx_busy      <= (state_nxt != IDLE);
      pkt_done_stb <= done_nxt;
      result_code  <= code_nxt;
    end
  end

  assign ctrl_state = state;

`ifdef OPENOFDM_RX_PKT_STATS_EN
  function automatic logic [15:0] cnt_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : (cnt + 16'd1);
  endfunction

  // Counts follow the registered strobe, so they land one cycle after pkt_done_stb.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      pkt_ok_cnt  <= 16'd0;
      pkt_err_cnt <= 16'd0;
    end else if (pkt_done_stb) begin
      if (result_code == CODE_OK) pkt_ok_cnt  <= cnt_inc(pkt_ok_cnt);
      else                        pkt_err_cnt <= cnt_inc(pkt_err_cnt);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_openofdm_rx_pkt_ctrl.sv
// Randomized bench for openofdm_rx_pkt_ctrl: packets are described as event times and the
// expected outcome is derived from per-stage deadlines, then compared with observed outputs.
module tb_openofdm_rx_pkt_ctrl;
  localparam int RST_CYCLES = 4;
  localparam int TMR_WIDTH  = 16;
  localparam int NONE       = 1000000;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enable = 1'b0;
  logic                 short_preamble_detected = 1'b0;
  logic                 long_preamble_detected = 1'b0;
  logic                 pkt_header_valid_strobe = 1'b0;
  logic                 pkt_header_valid = 1'b0;
  logic                 ht_unsupport = 1'b0;
  logic                 byte_out_strobe = 1'b0;
  logic                 fcs_out_strobe = 1'b0;
  logic                 fcs_ok = 1'b0;
  logic [TMR_WIDTH-1:0] cfg_long_tmo = '0;
  logic [TMR_WIDTH-1:0] cfg_sig_tmo = '0;
  logic [TMR_WIDTH-1:0] cfg_byte_tmo = '0;
  logic                 core_rst;
  logic                 rx_busy;
  logic [2:0]           ctrl_state;
  logic                 pkt_done_stb;
  logic [2:0]           result_code;
`ifdef OPENOFDM_RX_PKT_STATS_EN
  logic [15:0]          pkt_ok_cnt;
  logic [15:0]          pkt_err_cnt;
`endif

  openofdm_rx_pkt_ctrl #(.RST_CYCLES(RST_CYCLES), .TMR_WIDTH(TMR_WIDTH)) dut (
    .s00_axi_aclk            (clk),
    .s00_axi_aresetn         (rst_n),
    .enable                  (enable),
    .short_preamble_detected (short_preamble_detected),
    .long_preamble_detected  (long_preamble_detected),
    .pkt_header_valid_strobe (pkt_header_valid_strobe),
    .pkt_header_valid        (pkt_header_valid),
    .ht_unsupport            (ht_unsupport),
    .byte_out_strobe         (byte_out_strobe),
    .fcs_out_strobe          (fcs_out_strobe),
    .fcs_ok                  (fcs_ok),
    .cfg_long_tmo            (cfg_long_tmo),
    .cfg_sig_tmo             (cfg_sig_tmo),
    .cfg_byte_tmo            (cfg_byte_tmo),
    .core_rst                (core_rst),
    .rx_busy                 (rx_busy),
    .ctrl_state              (ctrl_state),
    .pkt_done_stb            (pkt_done_stb),
    .result_code             (result_code)
`ifdef OPENOFDM_RX_PKT_STATS_EN
    ,
    .pkt_ok_cnt              (pkt_ok_cnt),
    .pkt_err_cnt             (pkt_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scenario description: absolute cycle of each strobe, short preamble at cycle 0.
  int t_long, t_hdr, hdr_kind, nb, t_fcs, fcs_ok_v, t_dis, cl, cs, cb;
  int t_byte[8];
  int exp_term, exp_code;
  bit exp_abort;
  int model_ok = 0;
  int model_err = 0;

  // Earliest of disable, stage event and stage deadline; ties go disable > event > timeout.
  task automatic resolve(input int b, input int ev, input int cfg, output int t, output int why);
    int tt, tx;
    tt = (cfg != 0) ? b + cfg - 1 : NONE;
    tx = (t_dis >= 0) ? t_dis : NONE;
    if (tx <= ev && tx <= tt) begin t = tx; why = 2; end
    else if (ev <= tt)        begin t = ev; why = 0; end
    else                      begin t = tt; why = 1; end
  endtask

  task automatic model();
    int b, t, why;
    exp_abort = 1'b1;
    b = 1;
    resolve(b, t_long, cl, t, why);
    exp_term = t;
    if (why != 0) begin exp_code = (why == 2) ? 7 : 2; return; end
    b = t + 1;
    resolve(b, t_hdr, cs, t, why);
    exp_term = t;
    if (why != 0) begin exp_code = (why == 2) ? 7 : 3; return; end
    if (hdr_kind >= 2) begin exp_code = 5; return; end
    if (hdr_kind == 1) begin exp_code = 4; return; end
    b = t + 1;
    for (int i = 0; i < nb; i++) begin
      resolve(b, t_byte[i], cb, t, why);
      exp_term = t;
      if (why != 0) begin exp_code = (why == 2) ? 7 : 6; return; end
      b = t + 1;
    end
    resolve(b, t_fcs, cb, t, why);
    exp_term = t;
    if (why != 0) begin exp_code = (why == 2) ? 7 : 6; return; end
    exp_abort = 1'b0;
    exp_code  = fcs_ok_v ? 0 : 1;
  endtask

  task automatic idle_inputs();
    short_preamble_detected = 1'b0;
    long_preamble_detected  = 1'b0;
    pkt_header_valid_strobe = 1'b0;
    byte_out_strobe         = 1'b0;
    fcs_out_strobe          = 1'b0;
    enable                  = 1'b1;
  endtask

  task automatic run_pkt(input string name);
    int win, done_n, done_at, rst_cnt, rst_first;
    bit bs;
    model();
    win = exp_term + RST_CYCLES + 12;
    done_n = 0; done_at = -1; rst_cnt = 0; rst_first = -1;
    cfg_long_tmo = TMR_WIDTH'(cl);
    cfg_sig_tmo  = TMR_WIDTH'(cs);
    cfg_byte_tmo = TMR_WIDTH'(cb);
    for (int k = 0; k < win; k++) begin
      @(posedge clk); #1;
      enable = !(t_dis >= 0 && k >= t_dis);
      short_preamble_detected = (k == 0) || (k <= exp_term && $urandom_range(0, 7) == 0);
      long_preamble_detected  = (k == t_long);
      pkt_header_valid_strobe = (k == t_hdr);
      if (k == t_hdr) begin
        pkt_header_valid = (hdr_kind != 1 && hdr_kind != 3);
        ht_unsupport     = (hdr_kind >= 2);
      end else begin
        pkt_header_valid = 1'($urandom_range(0, 1));
        ht_unsupport     = 1'($urandom_range(0, 1));
      end
      bs = 1'b0;
      for (int i = 0; i < nb; i++) if (t_byte[i] == k) bs = 1'b1;
      byte_out_strobe = bs;
      fcs_out_strobe  = (k == t_fcs);
      fcs_ok = (k == t_fcs) ? 1'(fcs_ok_v) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (k == 1) check({name, ":state_wait_long"}, 32'(ctrl_state), 1);
      if (pkt_done_stb) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (core_rst) begin
        rst_cnt++;
        if (rst_first < 0) rst_first = k;
      end
      if (exp_abort && k == exp_term + 1) check({name, ":state_flush"}, 32'(ctrl_state), 4);
    end
    idle_inputs();
    check({name, ":done_count"}, 32'(done_n), 1);
    check({name, ":done_cycle"}, 32'(done_at), 32'(exp_term + 1));
    check({name, ":code"}, 32'(result_code), 32'(exp_code));
    check({name, ":rst_cycles"}, 32'(rst_cnt), exp_abort ? RST_CYCLES : 0);
    if (exp_abort) check({name, ":rst_with_done"}, 32'(rst_first), 32'(exp_term + 1));
    check({name, ":end_idle"}, 32'(ctrl_state), 0);
    check({name, ":end_busy"}, 32'(rx_busy), 0);
    if (exp_code == 0) model_ok++; else model_err++;
`ifdef OPENOFDM_RX_PKT_STATS_EN
    check({name, ":ok_cnt"}, 32'(pkt_ok_cnt), 32'(model_ok));
    check({name, ":err_cnt"}, 32'(pkt_err_cnt), 32'(model_err));
`endif
  endtask

  task automatic set_pkt(input int dl, input int dh, input int kind, input int n, input int gap,
                         input int dfcs, input int fok);
    t_long = dl; t_hdr = dl + dh; hdr_kind = kind; nb = n;
    for (int i = 0; i < n; i++) t_byte[i] = t_hdr + gap * (i + 1);
    t_fcs = (dfcs == NONE) ? NONE : t_hdr + gap * n + dfcs;
    fcs_ok_v = fok; t_dis = -1; cl = 0; cs = 0; cb = 0;
  endtask

  task automatic gen_random();
    int g;
    t_long = $urandom_range(1, 40);
    t_hdr  = t_long + $urandom_range(1, 60);
    g = $urandom_range(0, 9);
    hdr_kind = (g < 6) ? 0 : (g < 8) ? 1 : (g == 8) ? 2 : 3;
    nb = $urandom_range(0, 4);
    g = t_hdr;
    for (int i = 0; i < nb; i++) begin
      g += $urandom_range(1, 40);
      t_byte[i] = g;
    end
    t_fcs = g + $urandom_range(1, 40);
    fcs_ok_v = $urandom_range(0, 1);
    cl = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(5, 50);
    cs = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(5, 60);
    cb = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(5, 45);
    t_dis = ($urandom_range(0, 3) == 0) ? $urandom_range(1, t_fcs) : -1;
  endtask

  task automatic drive_cycle(input bit s, input bit l, input bit h);
    @(posedge clk); #1;
    short_preamble_detected = s;
    long_preamble_detected  = l;
    pkt_header_valid_strobe = h;
    pkt_header_valid        = 1'b1;
    ht_unsupport            = 1'b0;
    byte_out_strobe         = 1'b0;
    fcs_out_strobe          = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int done_seen;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst:state", 32'(ctrl_state), 0);
    check("rst:core_rst", 32'(core_rst), 0);
    check("rst:done", 32'(pkt_done_stb), 0);
    check("rst:code", 32'(result_code), 0);
    check("rst:busy", 32'(rx_busy), 0);
    rst_n = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);

    set_pkt(10, 200, 0, 5, 3, 5, 1);                 run_pkt("clean");
    set_pkt(NONE, 0, 0, 0, 1, 1, 1); cl = 100;       run_pkt("long_tmo");
    set_pkt(30, 5, 0, 2, 4, 4, 1);   cl = 30;        run_pkt("long_at_deadline");
    set_pkt(31, 5, 0, 2, 4, 4, 1);   cl = 30;        run_pkt("long_past_deadline");
    set_pkt(8, 12, 2, 0, 1, 1, 1);                   run_pkt("ht_unsup");
    set_pkt(8, 12, 1, 0, 1, 1, 1);                   run_pkt("hdr_invalid");
    set_pkt(8, 70, 0, 0, 1, 1, 1);   cs = 40;        run_pkt("sig_tmo");
    set_pkt(5, 10, 0, 4, 40, NONE, 1); cb = 50;      run_pkt("byte_tmo");
    set_pkt(5, 10, 0, 4, 40, 50, 0); cb = 50;        run_pkt("fcs_on_tmo_bad");
    set_pkt(5, 10, 0, 4, 40, 50, 1); cb = 50;        run_pkt("fcs_on_tmo_ok");
    set_pkt(10000, 30, 0, 3, 20, 20, 1);             run_pkt("no_tmo_10k");
    set_pkt(5, 10, 0, 3, 10, 60, 1); t_dis = 30;     run_pkt("disable_payload");

    // Asynchronous reset in the middle of a payload: nothing is reported for that packet.
    cfg_long_tmo = '0; cfg_sig_tmo = '0; cfg_byte_tmo = '0;
    drive_cycle(1, 0, 0);
    drive_cycle(0, 0, 0);
    drive_cycle(0, 1, 0);
    drive_cycle(0, 0, 0);
    drive_cycle(0, 0, 1);
    repeat (4) drive_cycle(0, 0, 0);
    @(negedge clk);
    check("mid_rst:payload", 32'(ctrl_state), 3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst:state", 32'(ctrl_state), 0);
    check("mid_rst:busy", 32'(rx_busy), 0);
    check("mid_rst:code", 32'(result_code), 0);
    check("mid_rst:core_rst", 32'(core_rst), 0);
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (pkt_done_stb) done_seen++;
    end
    rst_n = 1'b1;
    model_ok = 0; model_err = 0;
    repeat (6) begin
      @(negedge clk);
      if (pkt_done_stb) done_seen++;
    end
    check("mid_rst:no_strobe", 32'(done_seen), 0);
    check("mid_rst:idle", 32'(ctrl_state), 0);
    idle_inputs();

    set_pkt(4, 9, 0, 2, 6, 6, 1);                    run_pkt("post_rst_ok");
    set_pkt(4, 9, 1, 0, 1, 1, 1);                    run_pkt("post_rst_err");

    for (int n = 0; n < 40; n++) begin
      gen_random();
      run_pkt($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
